// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX paths: FSM encodings, parity modes,
// line idle level and a constant-foldable ceil(log2) helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic IDLE_LEVEL = 1'b1;

  // Usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags and a
// fall-through head word, so a pop can load the head on the same edge.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   level_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is refused even if a pop frees a slot on the same edge.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: FIFO-buffered words are framed
// (start, LSB-first data, optional parity, stop) one bit per baud tick.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic                       baud_tick_i,
  input  logic [DATA_BITS-1:0]       data_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  output logic                       uart_tx_o,
  output logic                       busy_o,
  output logic                       tx_done_o,
  output logic [clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int LW = clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic                 fifo_pop;
  logic                 push_ok;
  logic                 head_parity;
  logic [LW-1:0]        level_nxt;

  logic [2:0]           state_q,   state_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q,  parity_d;
  logic                 tx_q,      tx_d;
  logic                 done_q,    done_d;
  logic                 busy_q,    busy_d;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .push_i   (data_valid_i),
    .wdata_i  (data_i),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level)
  );

  assign push_ok      = data_valid_i && !fifo_full;
  assign data_ready_o = !fifo_full;

  // Parity is taken from the word as it leaves the FIFO and held for the frame.
  assign head_parity = (PARITY_MODE == PARITY_ODD) ? ~(^fifo_head) : (^fifo_head);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    if (baud_tick_i) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = IDLE_LEVEL;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head;
            parity_d = head_parity;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end
        end
        ST_START: begin
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            if (PARITY_MODE != PARITY_NONE) begin
              tx_d    = parity_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = IDLE_LEVEL;
              state_d = ST_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
        ST_PARITY: begin
          tx_d       = IDLE_LEVEL;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            // Chain straight into the next frame so there is no idle gap.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_head;
              parity_d = head_parity;
              tx_d     = 1'b0;
              state_d  = ST_START;
            end else begin
              tx_d    = IDLE_LEVEL;
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_d    = IDLE_LEVEL;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Busy is registered from next-state values so it tracks state/level exactly.
  assign level_nxt = fifo_level + LW'(push_ok) - LW'(fifo_pop);

  always_comb begin
    busy_d = (state_d != ST_IDLE) || (level_nxt != '0);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= IDLE_LEVEL;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_tx_o    = tx_q;
  assign tx_done_o    = done_q;
  assign busy_o       = busy_q;
  assign fifo_level_o = fifo_level;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: four configurations (8N1, 8E1, 8O1, 7N2)
// share clock/reset/tick; expected line bits are queued per word pushed.
module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic baud_tick = 1'b0;

  logic [7:0] d_n1 = '0, d_e1 = '0, d_o1 = '0;
  logic [6:0] d_s2 = '0;
  logic v_n1 = 1'b0, v_e1 = 1'b0, v_o1 = 1'b0, v_s2 = 1'b0;
  logic rdy_n1, rdy_e1, rdy_o1, rdy_s2;
  logic tx_n1, tx_e1, tx_o1, tx_s2;
  logic busy_n1, busy_e1, busy_o1, busy_s2;
  logic done_n1, done_e1, done_o1, done_s2;
  logic [2:0] lvl_n1, lvl_e1, lvl_o1, lvl_s2;

  int total = 0;
  int bad = 0;
  int cnt_n1 = 0, cnt_e1 = 0, cnt_o1 = 0, cnt_s2 = 0;
  int base;

  logic q_n1[$];
  logic q_e1[$];
  logic q_o1[$];
  logic q_s2[$];

  always #5 clk = ~clk;

  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .clk_i(clk), .resetn_i(resetn), .baud_tick_i(baud_tick), .data_i(d_n1),
    .data_valid_i(v_n1), .data_ready_o(rdy_n1), .uart_tx_o(tx_n1), .busy_o(busy_n1),
    .tx_done_o(done_n1), .fifo_level_o(lvl_n1));

  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .clk_i(clk), .resetn_i(resetn), .baud_tick_i(baud_tick), .data_i(d_e1),
    .data_valid_i(v_e1), .data_ready_o(rdy_e1), .uart_tx_o(tx_e1), .busy_o(busy_e1),
    .tx_done_o(done_e1), .fifo_level_o(lvl_e1));

  uart_tx_fifo_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
    .clk_i(clk), .resetn_i(resetn), .baud_tick_i(baud_tick), .data_i(d_o1),
    .data_valid_i(v_o1), .data_ready_o(rdy_o1), .uart_tx_o(tx_o1), .busy_o(busy_o1),
    .tx_done_o(done_o1), .fifo_level_o(lvl_o1));

  uart_tx_fifo_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s2 (
    .clk_i(clk), .resetn_i(resetn), .baud_tick_i(baud_tick), .data_i(d_s2),
    .data_valid_i(v_s2), .data_ready_o(rdy_s2), .uart_tx_o(tx_s2), .busy_o(busy_s2),
    .tx_done_o(done_s2), .fifo_level_o(lvl_s2));

  // Count every high cycle of tx_done, so a stretched pulse shows up as extra counts.
  always @(posedge clk) begin
    if (done_n1 === 1'b1) cnt_n1 <= cnt_n1 + 1;
    if (done_e1 === 1'b1) cnt_e1 <= cnt_e1 + 1;
    if (done_o1 === 1'b1) cnt_o1 <= cnt_o1 + 1;
    if (done_s2 === 1'b1) cnt_s2 <= cnt_s2 + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input int which, input logic b);
    case (which)
      0: q_n1.push_back(b);
      1: q_e1.push_back(b);
      2: q_o1.push_back(b);
      default: q_s2.push_back(b);
    endcase
  endtask

  // Expected line bits for one frame of the given configuration.
  task automatic exp_frame(input int which, input logic [8:0] d);
    int nb, pm, ns;
    logic p;
    case (which)
      0: begin nb = 8; pm = 0; ns = 1; end
      1: begin nb = 8; pm = 1; ns = 1; end
      2: begin nb = 8; pm = 2; ns = 1; end
      default: begin nb = 7; pm = 0; ns = 2; end
    endcase
    p = 1'b0;
    push_bit(which, 1'b0);
    for (int i = 0; i < nb; i++) begin
      push_bit(which, d[i]);
      p = p ^ d[i];
    end
    if (pm == 1) push_bit(which, p);
    else if (pm == 2) push_bit(which, ~p);
    for (int i = 0; i < ns; i++) push_bit(which, 1'b1);
  endtask

  task automatic push_word(input int which, input logic [8:0] d);
    case (which)
      0: begin d_n1 = d[7:0]; v_n1 = 1'b1; end
      1: begin d_e1 = d[7:0]; v_e1 = 1'b1; end
      2: begin d_o1 = d[7:0]; v_o1 = 1'b1; end
      default: begin d_s2 = d[6:0]; v_s2 = 1'b1; end
    endcase
    @(posedge clk); #1;
    v_n1 = 1'b0; v_e1 = 1'b0; v_o1 = 1'b0; v_s2 = 1'b0;
    $display("push dut=%0d data=0x%0h", which, d);
  endtask

  task automatic check_lines();
    logic e;
    if (q_n1.size() > 0) e = q_n1.pop_front(); else e = 1'b1;
    chk("line_n1", 16'(tx_n1), 16'(e));
    if (q_e1.size() > 0) e = q_e1.pop_front(); else e = 1'b1;
    chk("line_e1", 16'(tx_e1), 16'(e));
    if (q_o1.size() > 0) e = q_o1.pop_front(); else e = 1'b1;
    chk("line_o1", 16'(tx_o1), 16'(e));
    if (q_s2.size() > 0) e = q_s2.pop_front(); else e = 1'b1;
    chk("line_s2", 16'(tx_s2), 16'(e));
  endtask

  task automatic do_tick();
    baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
    check_lines();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, sampled while reset is held.
    #12;
    chk("rst_tx", 16'(tx_n1), 16'h1);
    chk("rst_busy", 16'(busy_n1), 16'h0);
    chk("rst_done", 16'(done_n1), 16'h0);
    chk("rst_ready", 16'(rdy_n1), 16'h1);
    chk("rst_level", 16'(lvl_n1), 16'h0);
    #4 resetn = 1'b1;
    @(posedge clk); #1;

    // One frame per configuration: 8N1 0x55, 8E1/8O1 0x07, 7N2 0x7F.
    push_word(0, 9'h055); exp_frame(0, 9'h055);
    push_word(1, 9'h007); exp_frame(1, 9'h007);
    push_word(2, 9'h007); exp_frame(2, 9'h007);
    push_word(3, 9'h07F); exp_frame(3, 9'h07F);
    chk("a_busy_after_push", 16'(busy_n1), 16'h1);
    chk("a_level_after_push", 16'(lvl_n1), 16'h1);
    repeat (10) do_tick();
    chk("a_done_not_yet", 16'(cnt_n1), 16'd0);
    chk("a_busy_in_stop", 16'(busy_n1), 16'h1);
    do_tick();
    chk("a_done_n1", 16'(cnt_n1), 16'd1);
    chk("a_busy_n1_low", 16'(busy_n1), 16'h0);
    chk("a_done_s2", 16'(cnt_s2), 16'd1);
    do_tick();
    chk("a_done_e1", 16'(cnt_e1), 16'd1);
    chk("a_done_o1", 16'(cnt_o1), 16'd1);
    chk("a_busy_e1_low", 16'(busy_e1), 16'h0);

    // Fill the FIFO with no ticks, then overflow.
    push_word(0, 9'h011); exp_frame(0, 9'h011);
    push_word(0, 9'h022); exp_frame(0, 9'h022);
    push_word(0, 9'h033); exp_frame(0, 9'h033);
    push_word(0, 9'h044); exp_frame(0, 9'h044);
    chk("b_level_full", 16'(lvl_n1), 16'd4);
    chk("b_ready_full", 16'(rdy_n1), 16'h0);
    push_word(0, 9'h055);
    chk("b_level_drop", 16'(lvl_n1), 16'd4);

    // Push on the pop tick while full: pop wins, push refused.
    base = cnt_n1;
    d_n1 = 8'h66; v_n1 = 1'b1; baud_tick = 1'b1;
    @(posedge clk); #1;
    v_n1 = 1'b0; baud_tick = 1'b0;
    $display("push dut=0 data=0x66 (on pop tick)");
    check_lines();
    chk("b_level_pop_push", 16'(lvl_n1), 16'd3);
    chk("b_ready_after_pop", 16'(rdy_n1), 16'h1);
    push_word(0, 9'h077); exp_frame(0, 9'h077);
    chk("b_level_refill", 16'(lvl_n1), 16'd4);
    chk("b_ready_refill", 16'(rdy_n1), 16'h0);
    repeat (3) @(posedge clk);
    #1;
    repeat (50) do_tick();
    chk("b_done_count", 16'(cnt_n1 - base), 16'd5);
    chk("b_busy_end", 16'(busy_n1), 16'h0);
    chk("b_level_end", 16'(lvl_n1), 16'd0);

    // Push coinciding with a tick in IDLE: held until the following tick.
    base = cnt_n1;
    d_n1 = 8'h3C; v_n1 = 1'b1; baud_tick = 1'b1;
    @(posedge clk); #1;
    v_n1 = 1'b0; baud_tick = 1'b0;
    $display("push dut=0 data=0x3c (on idle tick)");
    check_lines();
    exp_frame(0, 9'h03C);
    chk("c_level_held", 16'(lvl_n1), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    repeat (11) do_tick();
    chk("c_done_count", 16'(cnt_n1 - base), 16'd1);

    // Reset during data bit 3 of 0xA5 with two words queued behind it.
    push_word(0, 9'h0A5); exp_frame(0, 9'h0A5);
    push_word(0, 9'h011); exp_frame(0, 9'h011);
    push_word(0, 9'h022); exp_frame(0, 9'h022);
    repeat (5) do_tick();
    chk("d_level_mid", 16'(lvl_n1), 16'd2);
    chk("d_line_bit3", 16'(tx_n1), 16'h0);
    base = cnt_n1;
    #2 resetn = 1'b0;
    #1;
    chk("d_rst_tx", 16'(tx_n1), 16'h1);
    chk("d_rst_level", 16'(lvl_n1), 16'd0);
    chk("d_rst_busy", 16'(busy_n1), 16'h0);
    chk("d_rst_ready", 16'(rdy_n1), 16'h1);
    q_n1.delete();
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    repeat (20) do_tick();
    chk("d_no_done", 16'(cnt_n1 - base), 16'd0);
    chk("d_busy_idle", 16'(busy_n1), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised, single-clock UART transmitter. Replaces the fixed 8-bit transmitter that used a separate baud clock.
- Accepts bytes through a valid/ready handshake into an internal FIFO.
- Serialises each word LSB-first with configurable data width, parity and stop bits, advancing one bit per baud_tick_i pulse.
- Sits between the command/packet logic and the board UART pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
FIFO_DEPTH, 4, FIFO entries; power of two, 2..64.

Ports:
clk_i  in  1  system clock; all logic on posedge.
resetn_i  in  1  asynchronous active-low reset.
baud_tick_i  in  1  one-clk_i-cycle pulse, once per bit period.
data_i  in  DATA_BITS  word to transmit.
data_valid_i  in  1  data_i is valid.
data_ready_o  out  1  FIFO can accept a word (= !full).
uart_tx_o  out  1  serial line; idle high.
busy_o  out  1  FIFO non-empty or frame in flight.
tx_done_o  out  1  one-cycle pulse after the last stop bit completes.
fifo_level_o  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous): uart_tx_o=1, busy_o=0, tx_done_o=0, data_ready_o=1, fifo_level_o=0, FSM in IDLE, FIFO pointers cleared.
- Write: data_i is pushed when data_valid_i && data_ready_o at a clk_i edge. data_ready_o is registered from the pre-edge full flag.
- FIFO boundaries:
  - Push while full: ignored, data lost, no state change.
  - Push and pop in the same cycle while full: the pop succeeds, the push is refused (ready was low). Level goes to DEPTH-1.
  - Push and pop in the same cycle, non-full: level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on clk_i edges where baud_tick_i=1. uart_tx_o is registered and changes on those edges.
  - IDLE: line=1. On a tick with FIFO non-empty, pop the head into the shift register, drive 0, go to START.
  - START → DATA: on tick, drive bit 0 of the shift register, bit counter = 0.
  - DATA: on each tick, counter+1 and drive the next bit (LSB-first). After bit DATA_BITS-1 has been held a full tick:
    - PARITY_MODE != 0: go to PARITY and drive the parity bit.
    - PARITY_MODE = 0: go to STOP and drive 1.
  - Parity bit: even = XOR of the data bits; odd = XNOR. Computed from the latched word.
  - PARITY → STOP: on tick, drive 1, stop counter = 0.
  - STOP: held 1 for STOP_BITS ticks. On the tick ending the last stop bit:
    - Pulse tx_done_o for one clk_i cycle.
    - If the FIFO is non-empty, pop and drive 0 immediately (go to START). Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Frame length: 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS tick periods.
- A word written in the same cycle as a tick in IDLE with an empty FIFO is not sent on that tick. It starts on the next tick.
- busy_o = (state != IDLE) || (level != 0), registered.
- baud_tick_i pulses longer than one cycle: each high cycle counts as a tick. The source must guarantee single-cycle pulses.
- Reset mid-frame: line returns to 1 asynchronously, FIFO contents are discarded, no tx_done_o.
- data_i is latched at push. Later changes on data_i do not affect queued words.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encodings (3-bit IDLE=0 .. STOP=4).
  - PARITY_NONE/EVEN/ODD constants.
  - The IDLE_LEVEL=1 constant.
  - A clog2 function.
- One sub-module: uart_sync_fifo (parametrised width/depth, registered full/empty, level output). Reused later by the RX path.
- The serialiser FSM stays in the top module.

Test Plan:
- 8N1, push 0x55, ticks every 16 clk: uart_tx_o = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first, stop). tx_done_o pulses once after the 10th tick. busy_o falls after it.
- PARITY_MODE=1, push 0x07: frame 0,1,1,1,0,0,0,0,0,1(parity),1 (stop). With PARITY_MODE=2 the parity bit is 0.
- FIFO_DEPTH=4, no ticks: push 0x11,0x22,0x33,0x44 → level 4, data_ready_o=0. Fifth push 0x55 is dropped. Frames then appear in order 0x11..0x44 with no gaps, and tx_done_o pulses 4 times.
- Full FIFO, push on the pop tick: pop succeeds, push refused, level=3. Push next cycle is accepted, level=4.
- DATA_BITS=7, STOP_BITS=2, push 0x7F: 0, seven 1s, 1, 1 = 10 ticks, then idle high.
- Assert resetn_i low during data bit 3 of 0xA5 with 2 words queued: uart_tx_o=1 at once, level=0, no tx_done_o. After release the line stays 1 across 20 ticks.
